// File: rtl/moore_state_machine.sv
// Moore pulse-shape qualifier: classifies a serial strobe into idle, rise,
// sustained high, fall and glitch phases; the phase code is the state itself.
module moore_state_machine (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_i,
    output logic [2:0] out_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        RISE   = 3'b001,
        HIGH   = 3'b010,
        GLITCH = 3'b011,
        FALL   = 3'b100
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Unused codes fall to the default arm and recover to IDLE on the next edge.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = in_i ? RISE : IDLE;
            RISE:    state_nxt = in_i ? HIGH : GLITCH;
            HIGH:    state_nxt = in_i ? HIGH : FALL;
            FALL:    state_nxt = in_i ? RISE : IDLE;
            GLITCH:  state_nxt = in_i ? RISE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_o = state;

endmodule

// File: tb/tb_moore_state_machine.sv
// Scoreboard bench: stimulus pushes expected phase codes, a monitor pops and
// compares them one edge later; random traffic is checked by a run-length model.
module tb_moore_state_machine;

    logic       clk_i;
    logic       reset_i;
    logic       in_i;
    logic [2:0] out_o;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];

    // Reference model: length of the current run of ones and whether the
    // previous sampled input was high.
    int run_len = 0;
    bit prev_in = 1'b0;

    moore_state_machine dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .in_i   (in_i),
        .out_o  (out_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [2:0] model_step(input bit v, input bit rst);
        logic [2:0] e;
        if (!rst) begin
            run_len = 0;
            prev_in = 1'b0;
            e = 3'd0;
        end else if (v) begin
            run_len = run_len + 1;
            prev_in = 1'b1;
            e = (run_len == 1) ? 3'd1 : 3'd2;
        end else begin
            if (prev_in) e = (run_len == 1) ? 3'd3 : 3'd4;
            else         e = 3'd0;
            run_len = 0;
            prev_in = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge; push either the
    // model prediction or a fixed directed value.
    task automatic drive(input bit v, input bit rst, input bit use_const, input logic [2:0] c);
        logic [2:0] m;
        @(negedge clk_i);
        reset_i = rst;
        in_i    = v;
        m = model_step(v, rst);
        exp_q.push_back(use_const ? c : m);
    endtask

    task automatic directed(input logic [7:0] ins, input logic [23:0] exps, input int n);
        logic [2:0] e;
        for (int i = 0; i < n; i++) begin
            e = exps[3*i +: 3];
            drive(ins[i], 1'b1, 1'b1, e);
        end
    endtask

    task automatic settle();
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd0);
    endtask

    initial begin : monitor
        logic [2:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_o !== e) begin
                    errors++;
                    $display("FAIL phase_code t=%0t got=%0d exp=%0d", $time, out_o, e);
                end
            end
        end
    end

    initial begin : stimulus
        bit v;
        bit r;
        reset_i = 1'b0;
        in_i    = 1'b0;
        #1;
        checks++;
        if (out_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_async got=%0d exp=0", out_o);
        end

        // Held in reset, then released with a quiet input.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 3'd0);

        // Bits listed LSB first; codes packed 3 bits per step, first step lowest.
        directed(8'b0001_1111, {3'd0, 3'd4, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1}, 7);
        settle();
        directed(8'b0000_0001, {3'd0, 3'd3, 3'd1}, 3);
        settle();
        directed(8'b0001_1011, {3'd2, 3'd1, 3'd4, 3'd2, 3'd1}, 5);
        settle();
        directed(8'b0000_0101, {3'd3, 3'd1, 3'd3, 3'd1}, 4);
        settle();

        // Async reset while in HIGH, asserted mid-cycle.
        directed(8'b0000_0011, {3'd2, 3'd1}, 2);
        @(posedge clk_i);
        #3;
        reset_i = 1'b0;
        #1;
        checks++;
        if (out_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_in_high got=%0d exp=0", out_o);
        end
        void'(model_step(1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 1'b1, 3'd1);
        drive(1'b1, 1'b1, 1'b1, 3'd2);

        // Random traffic with a sticky input to get long runs and rare resets.
        v = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) v = ~v;
            if ($urandom_range(0, 5) == 0) v = $urandom_range(0, 1) == 1;
            r = ($urandom_range(0, 59) != 0);
            drive(v, r, 1'b0, 3'd0);
        end

        @(posedge clk_i);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
